// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: bus widths and the arbiter FSM encoding.
package sram_arbiter_pkg;

    localparam int ADDRESS_LEN       = 32;
    localparam int REGISTER_FILE_LEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_arb_picker.sv
// Combinational port selector for the SRAM arbiter.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module sram_arb_picker (
    input  logic [1:0] req,
    input  logic       pri_port,
    output logic       grant_valid,
    output logic       grant_port
);

    assign grant_valid = |req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // pri_port names the port that wins a tie; a lone requester always wins.
    assign grant_port = (&req) ? pri_port : ~req[0];
`else
    logic unused_pri_port;
    assign unused_pri_port = pri_port;
    assign grant_port      = ~req[0];
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of a single SRAM controller.
// Optional SRAM_ARB_ROUND_ROBIN_EN enables round-robin arbitration between the ports.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int DATA_W = REGISTER_FILE_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_done,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_done,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic              grant
);

    arb_state_t              state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic                    op_read_reg;
    logic                    grant_reg;
    logic [1:0]              req_vec;
    logic                    pick_valid, pick_port, pri_port;
    logic                    take_grant, capture;
    logic [1:0]              done_vec;
    logic [1:0][DATA_W-1:0]  rdata_bus;

    assign req_vec    = {req1_read | req1_write, req0_read | req0_write};
    assign take_grant = (state_reg == ARB_IDLE) && pick_valid;
    assign capture    = (state_reg == ARB_WAIT) && mem_ready && op_read_reg;

    sram_arb_picker u_picker (
        .req         (req_vec),
        .pri_port    (pri_port),
        .grant_valid (pick_valid),
        .grant_port  (pick_port)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Holds the port that wins the next tie: the one not granted last.
    logic pri_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pri_reg <= 1'b0;
        else if (take_grant)
            pri_reg <= ~pick_port;
    end
    assign pri_port = pri_reg;
`else
    assign pri_port = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= ARB_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:  if (pick_valid) state_next = ARB_ISSUE;
            ARB_ISSUE: state_next = ARB_WAIT;
            ARB_WAIT:  if (mem_ready) state_next = ARB_DONE;
            ARB_DONE:  state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // Read wins when a port raises both read and write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            op_read_reg <= 1'b0;
            grant_reg   <= 1'b0;
        end else if (take_grant) begin
            addr_reg    <= pick_port ? req1_addr  : req0_addr;
            wdata_reg   <= pick_port ? req1_wdata : req0_wdata;
            op_read_reg <= pick_port ? req1_read  : req0_read;
            grant_reg   <= pick_port;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic [DATA_W-1:0] rdata_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    rdata_reg <= '0;
                else if (capture && (grant_reg == 1'(gi)))
                    rdata_reg <= mem_read_data;
            end
            assign rdata_bus[gi] = rdata_reg;
            assign done_vec[gi]  = (state_reg == ARB_DONE) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign req0_rdata     = rdata_bus[0];
    assign req1_rdata     = rdata_bus[1];
    assign req0_done      = done_vec[0];
    assign req1_done      = done_vec[1];
    assign mem_read_en    = (state_reg == ARB_ISSUE) && op_read_reg;
    assign mem_write_en   = (state_reg == ARB_ISSUE) && !op_read_reg;
    assign mem_address    = addr_reg;
    assign mem_write_data = wdata_reg;
    assign grant          = grant_reg;

endmodule
